// File: rtl/pulse_counter_pkg.sv
// Shared constants and sizing helper for the pulse_counter tick generator.
// Legal parameter minimums live here so the top and the sub-module check them the same way.
package pulse_counter_pkg;

  localparam int unsigned MIN_MAX_COUNT  = 2;
  localparam int unsigned MIN_RESET_HOLD = 1;

  // Bits needed to encode 0..n-1, never less than one bit.
  function automatic int cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage : pulse_counter_pkg

// File: rtl/reset_hold_gen.sv
// Stretches the external synchronous reset by reset_hold_cycles clocks after release.
// ready rises on the edge that completes the hold; rst_int is its active-high complement.
module reset_hold_gen
  import pulse_counter_pkg::*;
#(
  parameter int unsigned reset_hold_cycles = 40
) (
  input  logic clk,
  input  logic reset,
  output logic rst_int,
  output logic ready
);

  localparam int                HOLD_W    = cnt_width(reset_hold_cycles);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(reset_hold_cycles - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  if (reset_hold_cycles < MIN_RESET_HOLD) begin : g_bad_hold
    $error("reset_hold_gen: reset_hold_cycles must be at least %0d", MIN_RESET_HOLD);
  end

  logic [HOLD_W-1:0] hold_cnt;
  logic              ready_q;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_cnt <= '0;
      ready_q  <= 1'b0;
    end else if (!ready_q) begin
      if (hold_cnt == HOLD_LAST) begin
        ready_q <= 1'b1;
      end else begin
        hold_cnt <= hold_cnt + HOLD_ONE;
      end
    end
  end

  assign ready   = ready_q;
  assign rst_int = ~ready_q;

endmodule : reset_hold_gen

// File: rtl/pulse_counter.sv
// Modulo-max_count enabled-cycle counter emitting a one-clock registered strobe per wrap.
// Counting is held off until the reset-hold stage reports ready.
module pulse_counter
  import pulse_counter_pkg::*;
#(
  parameter  int unsigned max_count         = 50,
  parameter  int unsigned reset_hold_cycles = 40,
  localparam int          CNT_W             = cnt_width(max_count)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             pulse,
  output logic [CNT_W-1:0] count,
  output logic             ready
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(max_count - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (max_count < MIN_MAX_COUNT) begin : g_bad_count
    $error("pulse_counter: max_count must be at least %0d", MIN_MAX_COUNT);
  end

  logic rst_int;

  reset_hold_gen #(
    .reset_hold_cycles(reset_hold_cycles)
  ) u_reset_hold (
    .clk    (clk),
    .reset  (reset),
    .rst_int(rst_int),
    .ready  (ready)
  );

  // External reset is honoured directly so a mid-count reset clears on the very next
  // edge, not one cycle later when rst_int catches up.
  always_ff @(posedge clk) begin
    if (!reset || rst_int) begin
      count <= '0;
      pulse <= 1'b0;
    end else if (enable) begin
      if (count == CNT_LAST) begin
        count <= '0;
        pulse <= 1'b1;
      end else begin
        count <= count + CNT_ONE;
        pulse <= 1'b0;
      end
    end else begin
      pulse <= 1'b0;
    end
  end

endmodule : pulse_counter

// File: tb/tb_pulse_counter.sv
// Bench for pulse_counter: default instance (50/40) and minimum instance (2/1) on shared
// stimulus, each compared every clock against an event-counting reference model.
module tb_pulse_counter;

  localparam int N_A = 50;
  localparam int H_A = 40;
  localparam int N_B = 2;
  localparam int H_B = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       pulse_a, ready_a;
  logic [5:0] count_a;
  logic       pulse_b, ready_b;
  logic [0:0] count_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pulse_counter #(.max_count(N_A), .reset_hold_cycles(H_A)) dut_a (
    .clk(clk), .reset(reset), .enable(enable),
    .pulse(pulse_a), .count(count_a), .ready(ready_a)
  );

  pulse_counter #(.max_count(N_B), .reset_hold_cycles(H_B)) dut_b (
    .clk(clk), .reset(reset), .enable(enable),
    .pulse(pulse_b), .count(count_b), .ready(ready_b)
  );

  // Model: count enabled edges since ready; count is that total mod n, and a pulse
  // follows every edge that makes the total a multiple of n.
  typedef struct packed {
    int     hold_left;
    bit     ready;
    longint events;
    bit     pulse;
  } model_t;

  model_t ma = '0;
  model_t mb = '0;

  function automatic model_t model_next(model_t m, int n, int h, bit rst, bit en);
    model_t r = m;
    r.pulse = 1'b0;
    if (!rst) begin
      r.hold_left = h;
      r.ready     = 1'b0;
      r.events    = 0;
    end else if (!m.ready) begin
      r.hold_left = m.hold_left - 1;
      r.ready     = (r.hold_left == 0);
    end else if (en) begin
      r.events = m.events + 1;
      r.pulse  = (r.events % n == 0);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    ma = model_next(ma, N_A, H_A, reset, enable);
    mb = model_next(mb, N_B, H_B, reset, enable);
    #1;
    check("a_pulse", 32'(pulse_a), 32'(ma.pulse));
    check("a_count", 32'(count_a), 32'(ma.events % N_A));
    check("a_ready", 32'(ready_a), 32'(ma.ready));
    check("b_pulse", 32'(pulse_b), 32'(mb.pulse));
    check("b_count", 32'(count_b), 32'(mb.events % N_B));
    check("b_ready", 32'(ready_b), 32'(mb.ready));
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b0;

    // Reset held, then released with enable low: ready rises after the hold only.
    repeat (10) step();
    check("a_reset_ready", 32'(ready_a), 32'd0);
    reset = 1'b1;
    repeat (H_A - 1) step();
    check("a_ready_early", 32'(ready_a), 32'd0);
    step();
    check("a_ready_on_time", 32'(ready_a), 32'd1);
    repeat (100 - H_A) step();

    // Continuous enable: two full wraps.
    enable = 1'b1;
    repeat (N_A - 1) step();
    check("a_count_49", 32'(count_a), 32'd49);
    check("a_no_pulse_yet", 32'(pulse_a), 32'd0);
    step();
    check("a_first_pulse", 32'(pulse_a), 32'd1);
    check("a_wrap_count", 32'(count_a), 32'd0);
    step();
    check("a_pulse_drop", 32'(pulse_a), 32'd0);
    repeat (N_A + 10) step();

    // Run to count 30 then reset mid-count.
    begin
      int guard = 0;
      while (ma.events % N_A != 30 && guard < 200) begin
        step();
        guard++;
      end
      check("reach_30_count", 32'(count_a), 32'd30);
    end
    reset = 1'b0;
    step();
    check("mid_reset_count", 32'(count_a), 32'd0);
    check("mid_reset_ready", 32'(ready_a), 32'd0);

    // Enable already high while the hold runs: counting starts only after ready.
    reset = 1'b1;
    repeat (H_A) step();
    check("hold_count_zero", 32'(count_a), 32'd0);
    repeat (N_A + 5) step();

    // One-on / one-off enable: disabled cycles freeze the count.
    for (int i = 0; i < 4 * N_A + 20; i++) begin
      enable = i[0];
      step();
    end

    // Randomized enable with occasional reset pulses.
    for (int i = 0; i < 600; i++) begin
      enable = 1'($urandom_range(0, 1));
      reset  = ($urandom_range(0, 199) != 0);
      step();
    end
    reset = 1'b1;
    enable = 1'b1;
    repeat (2 * N_A + H_A) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pulse_counter

// File: doc/pulse_counter.md
Name: pulse_counter

Overview:
- Free-running modulo-N event counter that emits a single-cycle strobe every max_count enabled clock cycles.
- Used as a clock-enable / tick generator, e.g. display refresh and sample-rate ticks.
- Contains a reset-hold stage that keeps the counter in reset for a fixed number of cycles after external reset releases.
- Reports readiness on a status output.

Parameters:
- max_count, 50, number of enabled cycles per output pulse; legal range 2..2^24.
- reset_hold_cycles, 40, clocks the internal reset stays asserted after external reset deasserts; legal range 1..2^16.
- CNT_W, $clog2(max_count), width of the count output (derived, not overridable).

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- enable  in  1  count-enable; counter advances only on edges where enable=1.
- pulse  out  1  registered strobe, high for exactly one clock per wrap.
- count  out  CNT_W  current count value, 0..max_count-1.
- ready  out  1  high once the internal reset-hold has expired.

Behaviour:
- Reset: synchronous, active-low, sampled on rising clk; the polarity and synchronicity are fixed.
- While reset=0: count=0, pulse=0, ready=0, hold counter cleared.
- Reset-hold:
  - After reset goes 1, internal rst_int stays asserted for reset_hold_cycles rising edges.
  - ready goes 1 on the edge that completes the hold and stays 1 until the next reset.
  - While rst_int is asserted: count=0, pulse=0, and enable is ignored.
- Counting, once ready=1:
  - On each rising edge with enable=1: if count==max_count-1 then count<=0 and pulse<=1; otherwise count<=count+1 and pulse<=0.
  - On each rising edge with enable=0: count holds and pulse<=0.
- Pulse timing:
  - With enable high continuously from count=0, pulse is high after exactly the max_count-th enabled edge.
  - It drops after the next edge.
  - Steady-state period is max_count clocks, duty 1/max_count.
- enable dropped on the wrap edge: pulse is still 1 for that cycle, then 0; count stays 0.
- Pausing: a gap in enable stretches the period; enabled edges accumulate and are not lost.
- Reset mid-count: the next edge clears count and pulse, and restarts the hold. The first pulse after release needs reset_hold_cycles edges plus max_count enabled edges.
- pulse and count are glitch-free registered outputs; there are no combinational paths from inputs to outputs.
- Compile-time guards: elaboration error if max_count<2 or reset_hold_cycles<1.

Decomposition:
- Shared package pulse_counter_pkg holds:
  - the clog2-based width helper function;
  - the MIN_MAX_COUNT constant (2);
  - the MIN_RESET_HOLD constant (1).
- One sub-module, reset_hold_gen:
  - inputs clk and reset;
  - outputs rst_int (active-high internal) and ready;
  - parameter reset_hold_cycles.
- The counter/pulse logic stays in the top module.

Test Plan:
- Hold reset=0 for 10 clocks, then release with enable=0 for 100 clocks -> pulse=0, count=0 throughout; ready rises exactly 40 clocks after release.
- After ready=1, drive enable=1 continuously -> pulse=1 only after the 50th enabled edge, 0 after the 51st; count sequence 0..49,0; next pulse after 50 more edges.
- Enable asserted before ready=1 -> count stays 0 until ready; the first pulse arrives 50 enabled edges after ready.
- Toggle enable 1 clock on / 1 clock off -> pulse after 50 enabled edges (≈100 clocks); count frozen on disabled cycles.
- Assert reset=0 at count=30 -> count=0, pulse=0, ready=0 on the next edge; after release the first pulse needs 40 hold + 50 enabled edges.
- Parameter sweep max_count=2, reset_hold_cycles=1 -> pulse every other enabled clock; ready 1 clock after release.
